// File: rtl/cardinal_nic.sv
// ============================================================================
// Module   : cardinal_nic
// Brief    : Core-to-router network interface with single-entry in/out
//            channel buffers and memory-mapped status registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:ADDR_WIDTH-1] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam logic [0:ADDR_WIDTH-1] c_ADDR_IN_BUF     = 'd0;
  localparam logic [0:ADDR_WIDTH-1] c_ADDR_IN_STATUS  = 'd1;
  localparam logic [0:ADDR_WIDTH-1] c_ADDR_OUT_BUF    = 'd2;
  localparam logic [0:ADDR_WIDTH-1] c_ADDR_OUT_STATUS = 'd3;

  logic [0:DATA_WIDTH-1] r_in_buf;
  logic                  r_in_full;
  logic [0:DATA_WIDTH-1] r_out_buf;
  logic                  r_out_full;
  logic                  r_net_so;
  logic [0:DATA_WIDTH-1] r_net_do;

  logic w_load;
  logic w_store;
  logic w_capture;
  logic w_consume;
  logic w_accept_store;
  logic w_send;

  assign w_load    = nicEn & ~nicWrEn;
  assign w_store   = nicEn & nicWrEn;
  assign w_capture = net_si & ~r_in_full;
  assign w_consume = w_load & (addr == c_ADDR_IN_BUF) & r_in_full;
  // A full out buffer blocks stores, so a store racing a send is always dropped.
  assign w_accept_store = w_store & (addr == c_ADDR_OUT_BUF) & ~r_out_full;
  // Virtual-channel bit must be on the opposite polarity to the router's cycle.
  assign w_send = r_out_full & net_ro & (r_out_buf[0] == ~net_polarity);

  assign net_ri = ~r_in_full;
  assign net_so = r_net_so;
  assign net_do = r_net_do;

  always_comb begin
    d_out = '0;
    if (w_load) begin
      case (addr)
        c_ADDR_IN_BUF:     d_out = r_in_buf;
        c_ADDR_IN_STATUS:  d_out = {{(DATA_WIDTH-1){1'b0}}, r_in_full};
        c_ADDR_OUT_BUF:    d_out = r_out_buf;
        c_ADDR_OUT_STATUS: d_out = {{(DATA_WIDTH-1){1'b0}}, r_out_full};
        default:           d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_buf  <= '0;
      r_in_full <= 1'b0;
    end else if (w_capture) begin
      r_in_buf  <= net_di;
      r_in_full <= 1'b1;
    end else if (w_consume) begin
      r_in_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_buf  <= '0;
      r_out_full <= 1'b0;
      r_net_so   <= 1'b0;
      r_net_do   <= '0;
    end else begin
      r_net_so <= 1'b0;
      if (w_send) begin
        r_net_so   <= 1'b1;
        r_net_do   <= r_out_buf;
        r_out_full <= 1'b0;
      end else if (w_accept_store) begin
        r_out_buf  <= d_in;
        r_out_full <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
